// File: rtl/mini_alu_16bit_mul_seq_if.sv
// Handshake bundle for the iterative multiplier: operand channel, result channel, cancel and status.
interface mini_alu_16bit_mul_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data0;
    logic [WIDTH-1:0]   data1;
    logic               abort;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               overflow;

    modport master (
        output in_valid, data0, data1, abort, out_ready,
        input  in_ready, busy, out_valid, product, overflow
    );

    modport slave (
        input  in_valid, data0, data1, abort, out_ready,
        output in_ready, busy, out_valid, product, overflow
    );
endinterface

// File: rtl/mini_alu_16bit_mul_seq.sv
// Shift-add multiplier: one WIDTH-bit adder stepped over WIDTH cycles, valid/ready on both sides.
module mini_alu_16bit_mul_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mini_alu_16bit_mul_seq_if.slave       bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    // Holds in_ready low until the first edge after reset release.
    logic             live_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            live_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        addend   = mplier_q[0] ? mcand_q : '0;
        sum      = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, addend};

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && live_q) begin
                    mcand_d  = bus.data0;
                    mplier_d = bus.data1;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.abort) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    // Carry lands in the accumulator MSB; the low product bits shift into mplier.
                    {acc_d, mplier_d} = {1'b0, sum, mplier_q[WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.abort || bus.out_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = live_q && (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.product   = {acc_q[WIDTH-1:0], mplier_q};
    assign bus.overflow  = |acc_q;
endmodule

// File: tb/tb_mini_alu_16bit_mul_seq.sv
// Scoreboard bench for the iterative multiplier: handshakes, latency, backpressure, abort and reset.
module tb_mini_alu_16bit_mul_seq;
    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [2*W:0] exp_q[$];

    mini_alu_16bit_mul_seq_if #(.WIDTH(W)) bus ();

    mini_alu_16bit_mul_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        return {(p[2*W-1:W] != '0), p};
    endfunction

    // Waits for in_ready (bounded) and presents one operand pair for exactly one edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input bit abort_too);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_eq("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.data0    = a;
        bus.data1    = b;
        bus.abort    = abort_too;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        bus.data0    = W'($urandom);
        bus.data1    = W'($urandom);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int bp, input bit abort_idle);
        int lat;
        logic [2*W:0] e;
        exp_q.push_back(golden(a, b));
        accept(a, b, abort_idle);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
                check_eq("calc_status", {62'd0, bus.in_ready, bus.busy}, 64'b01);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(W));
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 64'(exp_q.size()), 64'd1);
            return;
        end
        e = exp_q[0];
        bus.out_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            check_eq("bp_hold", {29'd0, bus.in_ready, bus.out_valid, bus.overflow, bus.product},
                     {29'd0, 1'b0, 1'b1, e});
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check_eq("product", 64'(bus.product), 64'(e[2*W-1:0]));
        check_eq("overflow", 64'(bus.overflow), 64'(e[2*W]));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("post_handoff", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    endtask

    initial begin
        logic [W-1:0] corners [3];
        logic [W-1:0] a, b;
        int seen;
        total = 0;
        bad   = 0;
        corners[0] = '0;
        corners[1] = W'(1);
        corners[2] = '1;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data0     = '0;
        bus.data1     = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {28'd0, bus.in_ready, bus.busy, bus.out_valid, bus.overflow, bus.product}, 64'd0);
        rst_n = 1'b1;
        #1 check_eq("rst_rel_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check_eq("first_ready", 64'(bus.in_ready), 64'd1);

        run_op(W'(3), W'(5), 0, 1'b0);
        run_op('1, '1, 0, 1'b0);
        run_op(W'(16'h0100), W'(16'h00FF), 0, 1'b0);
        run_op(W'(16'hABCD), W'(16'h1234), 5, 1'b0);
        run_op(W'(16'h0011), W'(16'h0022), 0, 1'b1);

        // abort on the 8th CALC cycle
        accept(W'(16'h1234), W'(16'h5678), 1'b0);
        repeat (7) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("abort_status", {61'd0, bus.busy, bus.out_valid, bus.in_ready}, 64'b001);
        seen = 0;
        repeat (20) begin
            if (bus.out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        check_eq("abort_no_valid", 64'(seen), 64'd0);
        run_op(W'(7), W'(9), 0, 1'b0);

        // abort together with out_ready in DONE
        accept(W'(16'h0F0F), W'(16'h0003), 1'b0);
        repeat (W) @(negedge clk);
        check_eq("done_valid", 64'(bus.out_valid), 64'd1);
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("abort_done", {61'd0, bus.busy, bus.out_valid, bus.in_ready}, 64'b001);

        // asynchronous reset in the middle of CALC
        accept(W'(16'hFFFF), W'(16'h00FF), 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst", {28'd0, bus.in_ready, bus.busy, bus.out_valid, bus.overflow, bus.product}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("rst2_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        run_op(W'(16'h8000), W'(2), 0, 1'b0);

        foreach (corners[i]) foreach (corners[j]) run_op(corners[i], corners[j], 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 2)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 2)] : W'($urandom);
            run_op(a, b, int'($urandom_range(0, 3)), 1'b0);
        end
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mini_alu_16bit_mul_seq.md
Name: mini_alu_16bit_mul_seq

Overview:
- Iterative shift-add multiplier controller for the mini ALU. It sequences a single WIDTH-bit adder over WIDTH cycles instead of a WIDTH-deep adder chain.
- Operands enter through a valid/ready handshake. The result leaves through a valid/ready handshake with backpressure.
- The unit sits between the ALU opcode decoder and the result mux, and replaces the combinational multiply path when area matters.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  unit can accept operands
data0  input  WIDTH  multiplicand, unsigned
data1  input  WIDTH  multiplier, unsigned
abort  input  1  synchronous cancel of the operation in flight
busy  output  1  operation accepted and not yet handed off
out_valid  output  1  product/overflow valid
out_ready  input  1  consumer accepts result
product  output  2*WIDTH  unsigned data0*data1
overflow  output  1  product[2*WIDTH-1:WIDTH] != 0, i.e. result does not fit WIDTH bits

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0, all datapath registers=0.
  - in_ready=0 while rst_n=0; in_ready=1 from the first clock after release.
  - busy=0, out_valid=0, product=0, overflow=0.
- States IDLE, CALC, DONE; one-hot or binary encoding at implementer's choice.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid & in_ready at edge k: latch mcand<=data0, mplier<=data1, acc<=0 (WIDTH+1 bits), cnt<=0, then go to CALC.
- CALC:
  - in_ready=0, busy=1.
  - Each edge: sum = acc[WIDTH-1:0] + (mplier[0] ? mcand : 0), WIDTH+1 bits including carry.
  - Each edge: {acc, mplier} <= {sum, mplier} >> 1, a logical shift with the carry entering the MSB. cnt<=cnt+1.
  - Exactly WIDTH iterations. On the edge where cnt==WIDTH-1, perform the final iteration and go to DONE.
- DONE:
  - out_valid=1, busy=1.
  - product={acc[WIDTH-1:0], mplier}; overflow=|acc[WIDTH-1:0]. Both are registered and stable while out_valid=1.
  - On out_valid & out_ready: go to IDLE. in_ready rises the next cycle; no same-cycle accept.
- Latency: operands accepted at edge k give out_valid=1 in the cycle after edge k+WIDTH (16 edges for WIDTH=16). Throughput is one op per WIDTH+2 cycles with out_ready held high.
- product/overflow after handoff: hold the last result until the next acceptance, then go don't-care (the bench must check them only when out_valid=1).
- Operands are sampled only at acceptance. Changes on data0/data1 during CALC/DONE have no effect.
- abort:
  - Sampled in CALC and DONE. At the edge where it is sampled high, go to IDLE, cnt<=0, and drop out_valid/busy in the next cycle.
  - abort in IDLE is ignored, and in_valid in that same cycle is still accepted.
  - If abort and out_ready are both high in DONE, the result is treated as handed off (same next state); report no error.
- in_valid while not in IDLE: ignored; the producer must hold it.
- Zero operands still take the full WIDTH cycles; there is no early termination.
- Reset asserted mid-CALC or mid-DONE: immediate return to the reset values listed above. The result is lost.

Test Plan:
- Reset, then in_valid with data0=3, data1=5 -> in_ready=0 for 16 cycles, then out_valid=1, product=0x0000000F, overflow=0. Handshake completes with out_ready=1, in_ready=1 one cycle later.
- data0=0xFFFF, data1=0xFFFF -> product=0xFFFE0001, overflow=1. Also data0=0x0100, data1=0x00FF -> product=0x0000FF00, overflow=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, product and overflow held constant, in_ready=0. Raise out_ready -> IDLE the next cycle.
- abort raised at the 8th CALC cycle of 0x1234*0x5678 -> busy=0 the next cycle, no out_valid. The next op 7*9 returns 0x0000003F.
- rst_n pulsed low mid-CALC -> out_valid/busy/product clear immediately without a clock edge. After release, 0x8000*2 returns 0x00010000, overflow=1.
- Back-to-back random operands (1000 ops, random out_ready) versus a golden data0*data1 -> all match. Checked at the 0-, 1-, 0xFFFF- operand corners.
